acc_cpu_core: RTL and testbench

Parametrised multi-cycle accumulator CPU core: the next generation of the 8-bit accumulator core, with configurable data/address width and register-file depth. It has an integrated controller state machine, Z/C flags, a conditional branch, a halt state and a single unified memory port with a req/ack handshake, so wait-state memories are supported. Instruction fetch, operand-address fetch and data load/store all share the same memory port. The block sits at SoC top level between the memory subsystem and debug/observation logic.

---
 rtl/acc_cpu_core.sv | 184 ++++++++++++++++++
 tb/tb_acc_cpu_core.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_core.sv
// acc_cpu_core
//   Multi-cycle accumulator CPU with a parametrised datapath. The controller
//   sequences FETCH -> DECODE -> (OPND -> (MEM)) through one unified memory
//   port. A transfer on that port completes in any cycle with req & ack, so
//   memories with wait states are supported.
//
// Ports
//   i_clk, i_rst        rising-edge clock, synchronous active-high reset
//   o_mem_req/we/addr/wdata, i_mem_rdata, i_mem_ack
//                       unified memory port with a req/ack handshake
//   o_acc, o_pc         accumulator, program counter
//   o_zero, o_carry     Z flag, C flag (carry on ADD, borrow on SUB)
//   o_halt              core is in the absorbing HALT state
module acc_cpu_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int NREG   = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_ack,
   output logic [DATA_W-1:0] o_acc,
   output logic [ADDR_W-1:0] o_pc,
   output logic              o_zero,
   output logic              o_carry,
   output logic              o_halt
);

   localparam int RW = $clog2(NREG);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_OPND, S_MEM, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      OP_HLT = 3'd0, OP_LDR = 3'd1, OP_STR = 3'd2, OP_ADD = 3'd3,
      OP_SUB = 3'd4, OP_LDA = 3'd5, OP_STA = 3'd6, OP_JZ  = 3'd7
   } op_t;

   state_t            state, state_nxt;
   op_t               ir_op;
   logic [RW-1:0]     ir_r;
   logic [ADDR_W-1:0] operand;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] acc;
   logic              zf, cf;
   logic [DATA_W-1:0] rf [NREG];

   logic              req_st;
   logic              xfer;
   logic [DATA_W-1:0] reg_val;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] diff;

   // Only the opcode, register index and operand fields of a read word are
   // decoded; the remaining bits are don't-care by design.
   logic unused_rdata;
   assign unused_rdata = ^i_mem_rdata;

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_FETCH;
      else       state <= state_nxt;
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  if (xfer) state_nxt = S_DECODE;
         S_DECODE: begin
            case (ir_op)
               OP_HLT:               state_nxt = S_HALT;
               OP_LDA, OP_STA, OP_JZ: state_nxt = S_OPND;
               default:              state_nxt = S_FETCH;
            endcase
         end
         S_OPND:   if (xfer) state_nxt = (ir_op == OP_JZ) ? S_FETCH : S_MEM;
         S_MEM:    if (xfer) state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_FETCH;
      endcase
   end

   // ---------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------
   always_comb begin
      req_st = (state == S_FETCH) || (state == S_OPND) || (state == S_MEM);
      // Gating with i_rst keeps the port quiet while reset is held, yet lets
      // the first cycle after release request address 0 straight away.
      o_mem_req   = req_st && !i_rst;
      o_mem_we    = (state == S_MEM) && (ir_op == OP_STA);
      o_mem_addr  = (state == S_MEM) ? operand : pc;
      o_mem_wdata = acc;
      o_halt      = (state == S_HALT);
   end

   assign xfer   = o_mem_req && i_mem_ack;
   assign o_acc   = acc;
   assign o_pc    = pc;
   assign o_zero  = zf;
   assign o_carry = cf;

   // ---------------------------------------------------------------
   // ALU
   // ---------------------------------------------------------------
   always_comb begin
      reg_val = rf[ir_r];
      sum     = {1'b0, acc} + {1'b0, reg_val};
      diff    = acc - reg_val;
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc      <= '0;
         acc     <= '0;
         zf      <= 1'b0;
         cf      <= 1'b0;
         ir_op   <= OP_HLT;
         ir_r    <= '0;
         operand <= '0;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (xfer) begin
                  ir_op <= op_t'(i_mem_rdata[DATA_W-1 -: 3]);
                  ir_r  <= i_mem_rdata[RW-1:0];
                  pc    <= pc + ADDR_W'(1);
               end
            end
            S_DECODE: begin
               case (ir_op)
                  OP_LDR: begin
                     acc <= reg_val;
                     zf  <= (reg_val == '0);
                  end
                  OP_STR: rf[ir_r] <= acc;
                  OP_ADD: begin
                     acc <= sum[DATA_W-1:0];
                     cf  <= sum[DATA_W];
                     zf  <= (sum[DATA_W-1:0] == '0);
                  end
                  OP_SUB: begin
                     acc <= diff;
                     cf  <= (reg_val > acc);
                     zf  <= (diff == '0);
                  end
                  default: ;
               endcase
            end
            S_OPND: begin
               if (xfer) begin
                  operand <= i_mem_rdata[ADDR_W-1:0];
                  // A taken JZ overrides the pc+1 step past the operand word.
                  if (ir_op == OP_JZ && zf) pc <= i_mem_rdata[ADDR_W-1:0];
                  else                      pc <= pc + ADDR_W'(1);
               end
            end
            S_MEM: begin
               if (xfer && ir_op == OP_LDA) begin
                  acc <= i_mem_rdata;
                  zf  <= (i_mem_rdata == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_cpu_core.sv
module tb_acc_cpu_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- 8-bit core ----------------
   logic       rst8 = 1'b1;
   logic       req8, we8, z8, c8, halt8;
   logic       ack8 = 1'b0;
   logic [7:0] addr8, wdata8, acc8, pc8;
   logic [7:0] rdata8 = '0;

   acc_cpu_core dut8 (
      .i_clk(clk), .i_rst(rst8),
      .o_mem_req(req8), .o_mem_we(we8), .o_mem_addr(addr8), .o_mem_wdata(wdata8),
      .i_mem_rdata(rdata8), .i_mem_ack(ack8),
      .o_acc(acc8), .o_pc(pc8), .o_zero(z8), .o_carry(c8), .o_halt(halt8)
   );

   // ---------------- 16-bit core ----------------
   logic        rst16 = 1'b1;
   logic        req16, we16, z16, c16, halt16;
   logic        ack16 = 1'b0;
   logic [11:0] addr16, pc16;
   logic [15:0] wdata16, acc16;
   logic [15:0] rdata16 = '0;

   acc_cpu_core #(.DATA_W(16), .ADDR_W(12), .NREG(16)) dut16 (
      .i_clk(clk), .i_rst(rst16),
      .o_mem_req(req16), .o_mem_we(we16), .o_mem_addr(addr16), .o_mem_wdata(wdata16),
      .i_mem_rdata(rdata16), .i_mem_ack(ack16),
      .o_acc(acc16), .o_pc(pc16), .o_zero(z16), .o_carry(c16), .o_halt(halt16)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   // ---------------- memory model for the 8-bit core ----------------
   logic [7:0] mem8 [256];
   logic [7:0] img  [256];
   logic [7:0] mm   [256];
   logic [7:0] trace [$];
   int         wt_cur = 0;
   int         wcnt = 0;
   logic       force_ack = 1'b0;
   logic [7:0] l_addr, l_wd;
   logic       l_we;

   // Decides ack/rdata on the falling edge; a write is committed when the
   // ack is granted since the core samples it on the next rising edge.
   always @(negedge clk) begin
      if (req8) begin
         if (wcnt == 0) begin
            l_addr = addr8; l_we = we8; l_wd = wdata8;
         end else begin
            check("hold.addr",  addr8,  l_addr);
            check("hold.we",    we8,    l_we);
            check("hold.wdata", wdata8, l_wd);
         end
         if (wcnt >= wt_cur || force_ack) begin
            ack8   = 1'b1;
            rdata8 = mem8[addr8];
            if (we8) mem8[addr8] = wdata8;
            trace.push_back(addr8);
            wcnt = 0;
         end else begin
            ack8   = 1'b0;
            rdata8 = 8'($urandom);
            wcnt++;
         end
      end else begin
         wcnt   = 0;
         ack8   = force_ack | 1'($urandom_range(0, 1));
         rdata8 = 8'($urandom);
      end
   end

   // ---------------- memory model for the 16-bit core ----------------
   logic [15:0] mem16 [4096];
   always @(negedge clk) begin
      ack16   = req16;
      rdata16 = req16 ? mem16[addr16] : 16'($urandom);
      if (req16 && we16) mem16[addr16] = wdata16;
   end

   // ---------------- ISA-level reference model ----------------
   // Executes the program in img[] instruction by instruction; cycles are
   // one per memory transfer (plus wt waits) and one per decode.
   task automatic model(input int wt, output logic [7:0] acc, output logic [7:0] pc,
                        output logic z, output logic c, output int cyc, output bit ok);
      logic [7:0] rf [32];
      logic [7:0] w, a;
      logic [8:0] s;
      int         r;
      for (int k = 0; k < 32; k++) rf[k] = '0;
      for (int k = 0; k < 256; k++) mm[k] = img[k];
      acc = 0; pc = 0; z = 0; c = 0; cyc = 0; ok = 0;
      for (int st = 0; st < 60 && !ok; st++) begin
         w = mm[pc]; pc = pc + 8'd1; cyc += 2 + wt;
         r = int'(w[4:0]);
         case (w[7:5])
            3'd0: ok = 1;
            3'd1: begin acc = rf[r]; z = (acc == 0); end
            3'd2: rf[r] = acc;
            3'd3: begin s = {1'b0, acc} + {1'b0, rf[r]}; acc = s[7:0]; c = s[8]; z = (acc == 0); end
            3'd4: begin c = (rf[r] > acc); acc = acc - rf[r]; z = (acc == 0); end
            default: begin
               a = mm[pc]; pc = pc + 8'd1; cyc += 1 + wt;
               if (w[7:5] == 3'd5) begin acc = mm[a]; z = (acc == 0); cyc += 1 + wt; end
               else if (w[7:5] == 3'd6) begin mm[a] = acc; cyc += 1 + wt; end
               else if (z) pc = a;
            end
         endcase
      end
   endtask

   function automatic int mem_diff();
      int n = 0;
      for (int k = 0; k < 256; k++) if (mem8[k] !== mm[k]) n++;
      return n;
   endfunction

   // Holds reset, loads img[] into memory, releases reset and counts cycles
   // from release until o_halt rises (bounded by limit).
   task automatic run_dut(input int wt, input int limit, output int cyc, output bit done);
      @(posedge clk); #1 rst8 = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      for (int k = 0; k < 256; k++) mem8[k] = img[k];
      trace.delete();
      wt_cur = wt;
      rst8 = 1'b0;
      cyc = 0; done = 0;
      while (!done && cyc < limit) begin
         @(negedge clk);
         if (halt8) done = 1;
         else cyc++;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      string      name;
      int         p0, pn, wt;
      logic [7:0] acc;
      logic       z, c;
      logic [7:0] pc;
      int         cyc;
      logic [7:0] ca, cd;
      int         tr_i;
      logic [7:0] tr_a;
   } vec_t;

   vec_t        vt [$];
   logic [15:0] pool [$];
   int          vstart = 0;

   task automatic put(input logic [7:0] a, input logic [7:0] d);
      pool.push_back({a, d});
   endtask

   task automatic add_vec(input string nm, input int wt, input logic [7:0] acc,
                          input logic z, input logic c, input logic [7:0] pc, input int cyc,
                          input logic [7:0] ca, input logic [7:0] cd,
                          input int tr_i, input logic [7:0] tr_a);
      vec_t v;
      v.name = nm; v.p0 = vstart; v.pn = pool.size() - vstart; v.wt = wt;
      v.acc = acc; v.z = z; v.c = c; v.pc = pc; v.cyc = cyc; v.ca = ca; v.cd = cd;
      v.tr_i = tr_i; v.tr_a = tr_a;
      vt.push_back(v);
      vstart = pool.size();
   endtask

   // LDA 0x1F (=5), STR r1, LDA 0x20 (=0x0A), ADD r1, STA 0x21, HLT
   task automatic prog_main();
      put(8'h00, 8'hA0); put(8'h01, 8'h1F); put(8'h02, 8'h41);
      put(8'h03, 8'hA0); put(8'h04, 8'h20); put(8'h05, 8'h61);
      put(8'h06, 8'hC0); put(8'h07, 8'h21); put(8'h08, 8'h00);
      put(8'h1F, 8'h05); put(8'h20, 8'h0A);
   endtask

   // LDA 0x31 (=1), STR r2, LDA 0x30 (=0xFF), ADD r2
   task automatic prog_carry();
      put(8'h00, 8'hA0); put(8'h01, 8'h31); put(8'h02, 8'h42);
      put(8'h03, 8'hA0); put(8'h04, 8'h30); put(8'h05, 8'h62);
      put(8'h30, 8'hFF); put(8'h31, 8'h01);
   endtask

   logic [7:0] macc, mpc;
   logic       mz, mc, mok_l;
   bit         mok, done;
   int         mcyc, cyc, k, wt;
   vec_t       v;

   initial begin
      // ---- build table ----
      prog_main();
      add_vec("zero_wait", 0, 8'h0F, 0, 0, 8'h09, 18, 8'h21, 8'h0F, -1, 8'h00);
      prog_main();
      add_vec("wait3",     3, 8'h0F, 0, 0, 8'h09, 54, 8'h21, 8'h0F, -1, 8'h00);
      // LDA 0x32 (=0), JZ 0x40 ; 0x40: LDA 0x33 (=0x77), HLT
      put(8'h00, 8'hA0); put(8'h01, 8'h32); put(8'h02, 8'hE0); put(8'h03, 8'h40);
      put(8'h04, 8'h00); put(8'h40, 8'hA0); put(8'h41, 8'h33); put(8'h42, 8'h00);
      put(8'h32, 8'h00); put(8'h33, 8'h77);
      add_vec("jz_taken",  0, 8'h77, 0, 0, 8'h43, 13, 8'h33, 8'h77, 5, 8'h40);
      // LDA 0x33 (=0x77), JZ 0x40 not taken, HLT at 4
      put(8'h00, 8'hA0); put(8'h01, 8'h33); put(8'h02, 8'hE0); put(8'h03, 8'h40);
      put(8'h04, 8'h00); put(8'h40, 8'hA0); put(8'h41, 8'h32); put(8'h42, 8'h00);
      put(8'h33, 8'h77);
      add_vec("jz_not",    0, 8'h77, 0, 0, 8'h05,  9, 8'h33, 8'h77, 5, 8'h04);
      // LDA 0x34, STR r3, LDA 0x35 (=0), LDR r3, STA 0x36, HLT
      put(8'h00, 8'hA0); put(8'h01, 8'h34); put(8'h02, 8'h43);
      put(8'h03, 8'hA0); put(8'h04, 8'h35); put(8'h05, 8'h23);
      put(8'h06, 8'hC0); put(8'h07, 8'h36); put(8'h08, 8'h00);
      put(8'h34, 8'h80); put(8'h35, 8'h00);
      add_vec("str_ldr",   1, 8'h80, 0, 0, 8'h09, 30, 8'h36, 8'h80, -1, 8'h00);
      prog_carry(); put(8'h06, 8'h00);
      add_vec("carry",     0, 8'h00, 1, 1, 8'h07, 14, 8'h30, 8'hFF, -1, 8'h00);
      prog_carry(); put(8'h06, 8'h82); put(8'h07, 8'h00);
      add_vec("borrow",    2, 8'hFF, 0, 1, 8'h08, 36, 8'h30, 8'hFF, -1, 8'h00);

      // ---- hand-written: long instruction spanning 0xFF/0x00 ----
      // LDR r0 (Z=1), JZ 0xFF ; 0xFF: LDA <0x00 holds 0x20> ; 0x01: JZ (not taken), HLT
      for (k = 0; k < 256; k++) img[k] = '0;
      img[8'h00] = 8'h20; img[8'h01] = 8'hE0; img[8'h02] = 8'hFF;
      img[8'hFF] = 8'hA0; img[8'h20] = 8'h5A;
      run_dut(0, 40, cyc, done);
      check("wrap.halted", done, 1);
      check("wrap.cycles", cyc, 14);
      check("wrap.acc", acc8, 8'h5A);
      check("wrap.pc", pc8, 8'h04);
      check("wrap.ntrans", trace.size(), 9);
      if (trace.size() >= 7) begin
         check("wrap.opnd_addr", trace[4], 8'h00);
         check("wrap.next_fetch", trace[6], 8'h01);
      end

      // ---- table loop ----
      for (int i = 0; i < vt.size(); i++) begin
         v = vt[i];
         for (k = 0; k < 256; k++) img[k] = '0;
         for (k = v.p0; k < v.p0 + v.pn; k++) img[pool[k][15:8]] = pool[k][7:0];
         model(v.wt, macc, mpc, mz, mc, mcyc, mok);
         run_dut(v.wt, v.cyc + 20, cyc, done);
         check({v.name, ".halted"}, done, 1);
         check({v.name, ".cycles"}, cyc, v.cyc);
         check({v.name, ".acc"}, acc8, v.acc);
         check({v.name, ".z"}, z8, v.z);
         check({v.name, ".c"}, c8, v.c);
         check({v.name, ".pc"}, pc8, v.pc);
         check({v.name, ".mem"}, mem8[v.ca], v.cd);
         check({v.name, ".mem_vs_model"}, mem_diff(), 0);
         if (v.tr_i >= 0) begin
            if (trace.size() > v.tr_i) check({v.name, ".fetch_addr"}, trace[v.tr_i], v.tr_a);
            else check({v.name, ".ntrans"}, trace.size(), v.tr_i + 1);
         end
      end

      // ---- hand-written: reset during a stalled STA ----
      for (k = 0; k < 256; k++) img[k] = '0;
      img[8'h00] = 8'hC0; img[8'h01] = 8'h21; img[8'h21] = 8'h33;
      @(posedge clk); #1 rst8 = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      for (k = 0; k < 256; k++) mem8[k] = img[k];
      check("rst.req_held", req8, 0);
      check("rst.acc", acc8, 0);
      check("rst.pc", pc8, 0);
      check("rst.z", z8, 0);
      check("rst.c", c8, 0);
      check("rst.halt", halt8, 0);
      wt_cur = 10;
      rst8 = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!(req8 && we8) && k < 60);
      check("rst.reach_mem", req8 && we8, 1);
      @(negedge clk);
      @(posedge clk); #1 rst8 = 1'b1; force_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst.req_drop", req8, 0);
      @(posedge clk); #1 rst8 = 1'b0; force_ack = 1'b0;
      @(negedge clk);
      check("rst.rel_req", req8, 1);
      check("rst.rel_addr", addr8, 0);
      check("rst.rel_we", we8, 0);
      check("rst.rel_acc", acc8, 0);
      check("rst.rel_pc", pc8, 0);
      check("rst.rel_flags", {z8, c8, halt8}, 0);
      check("rst.no_write", mem8[8'h21], 8'h33);

      // ---- randomized programs against the ISA model ----
      for (int n = 0; n < 40; n++) begin
         mok = 0;
         wt = $urandom_range(0, 2);
         for (int t = 0; t < 50 && !mok; t++) begin
            for (k = 0; k < 256; k++) img[k] = 8'($urandom);
            model(wt, macc, mpc, mz, mc, mcyc, mok);
         end
         if (mok) begin
            run_dut(wt, mcyc + 20, cyc, done);
            check("rnd.halted", done, 1);
            check("rnd.cycles", cyc, mcyc);
            check("rnd.acc", acc8, macc);
            check("rnd.pc", pc8, mpc);
            check("rnd.flags", {z8, c8}, {mz, mc});
            check("rnd.mem", mem_diff(), 0);
         end
      end

      // ---- 16-bit instance: 0xFFFF + 1 ----
      for (k = 0; k < 4096; k++) mem16[k] = '0;
      mem16[0] = 16'hA000; mem16[1] = 16'h0031; mem16[2] = 16'h4002;
      mem16[3] = 16'hA000; mem16[4] = 16'h0030; mem16[5] = 16'h6002;
      mem16[6] = 16'h0000; mem16[12'h30] = 16'hFFFF; mem16[12'h31] = 16'h0001;
      @(posedge clk); #1 rst16 = 1'b0;
      cyc = 0; done = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         if (halt16) done = 1;
         else cyc++;
      end
      check("w16.halted", done, 1);
      check("w16.cycles", cyc, 14);
      check("w16.acc", acc16, 16'h0000);
      check("w16.z", z16, 1);
      check("w16.c", c16, 1);
      check("w16.pc", pc16, 12'h007);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
